// File: rtl/neuron_ctrl.sv
// neuron_ctrl: sequencer for one fully-connected neuron.
// Streams one activation per cycle against weights read from weight_mem.
// Accumulates the products, adds the bias, rescales by frac_bits and saturates.
// The result is presented on a valid/ready output.
// Optional feature: define NEURON_RELU_EN to clamp negative results to zero.
module neuron_ctrl #(
  parameter int NUM_WEIGHT    = 3,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [DATA_WIDTH-1:0]    bias,
  output logic                     r_en,
  output logic [ADDRESS_WIDTH-1:0] r_add,
  input  logic [DATA_WIDTH-1:0]    w_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data
);

  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam int ACC_W = 2*DATA_WIDTH + ADDRESS_WIDTH;
  localparam int PW    = 2*DATA_WIDTH;

  localparam logic [CW-1:0] LAST = CW'(NUM_WEIGHT - 1);

  // Saturation bounds expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]    out_q, out_d;

  // Datapath helpers
  logic signed [PW-1:0]         prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      bias_ext;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      scaled;
  logic [DATA_WIDTH-1:0]        sat;
  logic [DATA_WIDTH-1:0]        res;
  logic [CW-1:0]                cnt_inc;

  // Full-width signed product, sign-extended to the accumulator
  assign prod     = $signed(in_data) * $signed(w_out);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Bias is aligned to the product's fractional point before the add
  assign bias_ext = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
  assign sum      = acc_q + bias_ext;
  assign scaled   = sum >>> FRAC_BITS;
  assign cnt_inc  = cnt_q + 1'b1;

  // Clamp the rescaled sum into the output range
  always_comb begin
    if (scaled > SAT_MAX)
      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (scaled < SAT_MIN)
      sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat = scaled[DATA_WIDTH-1:0];
  end

`ifdef NEURON_RELU_EN
  assign res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  // State, counter, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Next-state and handshake/read-port outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_d     = out_q;
    r_en      = 1'b0;
    r_add     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        // Prefetch weight 0 so it is on w_out for the first input
        r_en    = 1'b1;
        r_add   = '0;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q == LAST) begin
            state_d = S_BIAS;
          end else begin
            // Fetch the weight for the next input; without a handshake
            // the memory holds the current weight on w_out
            r_en  = 1'b1;
            r_add = cnt_inc[ADDRESS_WIDTH-1:0];
            cnt_d = cnt_inc;
          end
        end
      end
      S_BIAS: begin
        out_d   = res;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_neuron_ctrl.sv
// Testbench for neuron_ctrl (Q8.8, three weights).
// The test covers directed cases for the basic, gapped, saturation, ReLU,
// backpressure and reset-mid-accumulate scenarios, followed by randomized neurons.
// All results are checked against an arithmetic reference model.
module tb_neuron_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] bias;
  logic        r_en;
  logic [9:0]  r_add;
  logic [15:0] w_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  neuron_ctrl #(
    .NUM_WEIGHT(3), .ADDRESS_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bias(bias),
    .r_en(r_en), .r_add(r_add), .w_out(w_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // weight_mem model: registered read, holds output while r_en is low
  logic [15:0] wmem [0:1023];
  always @(posedge clk) if (r_en) w_out <= wmem[r_add];

  // Record every read address issued
  logic [9:0] rq [$];
  always @(posedge clk) if (!rst && r_en) rq.push_back(r_add);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] xv [0:2];

  // Reference: floor((sum x*w + bias*2^8) / 2^8), saturated, optional ReLU
  function automatic logic [15:0] ref_out(input logic [15:0] b);
    longint s, q;
    s = 0;
    for (int i = 0; i < 3; i++)
      s += longint'($signed(xv[i])) * longint'($signed(wmem[i]));
    s += longint'($signed(b)) * 256;
    q = s / 256;
    if ((s % 256 != 0) && (s < 0)) q -= 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`ifdef NEURON_RELU_EN
    if (q < 0) q = 0;
`endif
    return 16'(q);
  endfunction

  // Drive one neuron: gap idle cycles between inputs, bp extra cycles of out_ready=0
  task automatic run_neuron(input logic [15:0] b, input int gap, input int bp);
    logic [15:0] exp_v;
    bit hs;
    int waits;
    exp_v = ref_out(b);
    bias = b;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          tick();
          chk("r_en_idle", r_en, 0);
        end
      end
      in_valid = 1'b1;
      in_data  = xv[i];
      hs = 0;
      waits = 0;
      while (!hs && waits < 20) begin
        hs = in_ready;
        tick();
        waits++;
      end
      if (!hs) chk("in_hs_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    // T+1: BIAS
    chk("ov_bias", out_valid, 0);
    chk("ir_bias", in_ready, 0);
    tick();
    // T+2: OUT
    chk("ov_rise", out_valid, 1);
    chk("out_data", out_data, exp_v);
    chk("rd_count", rq.size(), 3);
    for (int i = 0; i < rq.size() && i < 3; i++) chk("rd_addr", rq[i], i);
    rq.delete();
    repeat (bp) begin
      tick();
      chk("ov_hold", out_valid, 1);
      chk("od_hold", out_data, exp_v);
      chk("ir_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // U+1: LOAD
    chk("ov_fall", out_valid, 0);
    chk("ir_load", in_ready, 0);
    tick();
    // U+2: ACC
    chk("ir_u2", in_ready, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_r_add", r_add, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  // Deassert reset and check the LOAD / first-ready timing
  task automatic release_reset();
    rst = 1'b0;
    rq.delete();
    chk("r_in_ready", in_ready, 0);
    tick();
    chk("r1_in_ready", in_ready, 0);
    chk("r1_r_en", r_en, 1);
    chk("r1_r_add", r_add, 0);
    tick();
    chk("r2_in_ready", in_ready, 1);
  endtask

  task automatic set_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    xv[0] = a;
    xv[1] = b;
    xv[2] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) wmem[i] = 16'h0000;
    wmem[0] = 16'h0100;
    wmem[1] = 16'h0200;
    wmem[2] = 16'hFF80;
    w_out = 16'h0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0;
    bias = 16'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals();
    release_reset();

    // Basic
    set_x(16'h0100, 16'h0100, 16'h0200);
    run_neuron(16'h0080, 0, 0);
    // Gapped input
    run_neuron(16'h0080, 3, 0);
    // Saturation, both directions
    set_x(16'h7FFF, 16'h7FFF, 16'h0000);
    run_neuron(16'h7FFF, 0, 0);
    set_x(16'h8000, 16'h8000, 16'h0000);
    run_neuron(16'h8000, 1, 0);
    // Negative result (ReLU-sensitive)
    set_x(16'hFF00, 16'h0000, 16'h0000);
    run_neuron(16'h0000, 0, 0);
    // Backpressure
    set_x(16'h0100, 16'h0100, 16'h0200);
    run_neuron(16'h0080, 0, 5);

    // Reset mid-ACC after two inputs
    set_x(16'h7000, 16'h7000, 16'h0000);
    in_valid = 1'b1;
    in_data = xv[0];
    tick();
    in_data = xv[1];
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    tick();
    chk_reset_vals();
    release_reset();
    set_x(16'h0100, 16'h0100, 16'h0200);
    run_neuron(16'h0080, 0, 0);

    // Randomized neurons
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 5))
          0: xv[i] = 16'h7FFF;
          1: xv[i] = 16'h8000;
          default: xv[i] = 16'($urandom);
        endcase
      end
      run_neuron(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_ctrl.md
# neuron_ctrl

Sequencer for one fully-connected neuron. It streams one input activation per cycle against weights fetched from the neuron's `weight_mem`, accumulates the products, adds a bias, and rescales and saturates the sum. It then presents one activation on a valid/ready output. It sits between the layer input stream and the layer output collector, and owns the `weight_mem` read port (`r_en`, `r_add`, `w_out`).

## Interface
- `num_weight`, 3: inputs per neuron, which is also the number of weights read; range 1..2^address_width.
- `address_width`, 10: width of the `weight_mem` address.
- `data_width`, 16: signed fixed-point width of activations, weights, bias and output.
- `frac_bits`, 8: fractional bits of the fixed-point format.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; every register is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input activation valid.
- `in_ready` output 1: controller accepts the input.
- `in_data` input data_width: signed input activation.
- `bias` input data_width: signed bias; sampled in state BIAS.
- `r_en` output 1: `weight_mem` read enable.
- `r_add` output address_width: `weight_mem` read address.
- `w_out` input data_width: weight returned one cycle after `r_en`; `weight_mem` holds it while `r_en`=0.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output data_width: signed result.

## Operation
- FSM states: IDLE, LOAD, ACC, BIAS, OUT. Counter `cnt` is address_width+1 bits; accumulator `acc` is signed, 2*data_width+address_width bits.
- IDLE: all outputs low; moves to LOAD unconditionally.
- LOAD: `r_en`=1, `r_add`=0, `cnt`←0, `acc`←0; moves to ACC.
- ACC: `in_ready`=1. On `in_valid`&&`in_ready`:
  - `acc` += `in_data`*`w_out`, using a full-width signed product;
  - if `cnt`==num_weight-1, go to BIAS with `r_en`=0;
  - otherwise `r_en`=1, `r_add`=`cnt`+1, `cnt`++, and stay in ACC.
  - With no handshake: `r_en`=0 and `w_out` is held.
- BIAS: `in_ready`=0.
  - Compute s = (`acc` + sign-extended `bias`<<frac_bits) >>> frac_bits (arithmetic shift, truncation toward −∞).
  - Saturate s to [−2^(data_width−1), 2^(data_width−1)−1] and register it into `out_data`.
  - Move to OUT.
- OUT: `out_valid`=1 and `out_data` is stable. When `out_ready`=1, go to LOAD.
- `in_ready` is low in every state except ACC. Inputs are never dropped or duplicated.
- num_weight=1: the single handshake in ACC goes straight to BIAS, and no second read is issued.
- Reset, including during ACC, BIAS or OUT: state←IDLE, `acc`, `cnt` and `out_data`←0, and any partial sum is discarded. A transfer that is active when reset asserts is lost.

## Timing
- Reset values: `in_ready`=0, `r_en`=0, `r_add`=0, `out_valid`=0, `out_data`=0.
- After reset deasserts at cycle R: LOAD at R+1, and `in_ready`=1 first at R+2.
- Weight read latency is 1 cycle. The read issued on a handshake at cycle t is consumed at t+1 or later.
- Throughput is one input per cycle while `in_valid` stays high.
- If the last handshake occurs at cycle T, `out_valid` rises at T+2.
- If the output handshake occurs at cycle U, `in_ready` is next high at U+2.
- Minimum neuron period is num_weight+3 cycles.

## Configuration
- `NEURON_RELU_EN`:
  - When defined, the saturated result passes through ReLU in BIAS: negative values become 0.
  - When undefined, signed results are output unchanged.
  - Latency is identical in both builds.

## Test plan
All scenarios use Q8.8 with num_weight=3 and weights {0x0100, 0x0200, 0xFF80}.
- Basic: inputs {0x0100, 0x0100, 0x0200}, bias 0x0080 → `out_data`=0x0280 with `out_valid` at T+2; `r_add` sequence is 0, 1, 2.
- Gapped input: `in_valid` low for 3 cycles between each input → same 0x0280; `r_en` pulses only on LOAD and on handshakes.
- Saturation: inputs {0x7FFF, 0x7FFF, 0x0000}, bias 0x7FFF → 0x7FFF. Inputs {0x8000, 0x8000, 0x0000}, bias 0x8000 → 0x8000, or 0x0000 with `NEURON_RELU_EN`.
- ReLU: inputs {0xFF00, 0x0000, 0x0000}, bias 0 → 0xFF00 without the macro and 0x0000 with it.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_data` is stable and `in_ready`=0 throughout; `in_ready` is high 2 cycles after the handshake.
- Reset mid-ACC after 2 inputs, then run the basic stimulus → 0x0280, with no contamination from the prior partial sum.
